// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the EX-stage HI/LO sequencer and its surroundings:
// the EX pipeline controls, the multiplier IP, the iterative divider and the
// HI/LO result.
interface muldiv_ctrl_if;
    // EX-stage request and pipeline controls
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        flush_i;
    logic        except_i;
    logic        ex_hold_i;

    // Fixed-latency multiplier IP
    logic        mul_ce_o;
    logic        mul_sign_o;
    logic        mul_sclr_o;
    logic [63:0] mul_p_i;

    // Iterative divider
    logic        div_start_o;
    logic        div_signed_o;
    logic        div_cancel_o;
    logic        div_done_i;
    logic [31:0] div_q_i;
    logic [31:0] div_r_i;

    // Pipeline status and result
    logic        stall_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    // Sequencer side
    modport slave (
        input  start_i, op_i, rs_i, rt_i, flush_i, except_i, ex_hold_i,
        output mul_ce_o, mul_sign_o, mul_sclr_o,
        input  mul_p_i,
        output div_start_o, div_signed_o, div_cancel_o,
        input  div_done_i, div_q_i, div_r_i,
        output stall_o, busy_o, result_valid_o, hi_o, lo_o
    );

    // Environment side (EX stage, multiplier, divider)
    modport master (
        output start_i, op_i, rs_i, rt_i, flush_i, except_i, ex_hold_i,
        input  mul_ce_o, mul_sign_o, mul_sclr_o,
        output mul_p_i,
        input  div_start_o, div_signed_o, div_cancel_o,
        output div_done_i, div_q_i, div_r_i,
        input  stall_o, busy_o, result_valid_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO sequencer for the EX stage. Runs MULT/MULTU through a
// fixed-latency multiplier IP and DIV/DIVU through an iterative divider,
// stalls EX while the operation is in flight and holds a registered HI/LO.
module muldiv_ctrl #(
    parameter int MUL_LAT = 9
) (
    input logic          clk_i,
    input logic          rst_ni,
    muldiv_ctrl_if.slave bus
);
    localparam int CNT_W = (MUL_LAT > 16) ? $clog2(MUL_LAT) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_MUL_CAP,
        S_DIV_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q;
    logic [31:0]      hi_q, lo_q;

    logic launch;
    logic is_div;
    logic rt_zero;
    logic cap_mul;
    logic cap_div;
    logic cap_dz;

    // NOTE: launch is qualified by rst_ni so that while reset is held every
    // output is 0, even with start_i still high from the interrupted instruction.
    assign launch  = rst_ni && (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
    assign is_div  = bus.op_i[1];
    assign rt_zero = (bus.rt_i == 32'd0);

    // Capture points for the result registers; a flush cancels any capture.
    assign cap_mul = (state_q == S_MUL_CAP) && !bus.flush_i;
    assign cap_div = (state_q == S_DIV_WAIT) && bus.div_done_i && !bus.flush_i;
    assign cap_dz  = launch && is_div && rt_zero;

    // Next-state and multiply-latency counter
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    if (!is_div) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                    end else if (rt_zero) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV_WAIT;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_MUL_CAP;
            end
            S_MUL_CAP:  state_d = S_DONE;
            S_DIV_WAIT: if (bus.div_done_i) state_d = S_DONE;
            S_DONE:     if (!bus.ex_hold_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (bus.flush_i) state_d = S_IDLE;
    end

    // State, counter and operation sign registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the values from before this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (launch) sign_q <= ~bus.op_i[0];
        end
    end

    // HI/LO result registers, loaded only on a capture edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the result registers are reset so hi_o/lo_o read zero
            // until the first operation completes.
            hi_q <= '0;
            lo_q <= '0;
        end else if (cap_mul) begin
            hi_q <= bus.mul_p_i[63:32];
            lo_q <= bus.mul_p_i[31:0];
        end else if (cap_div) begin
            hi_q <= bus.div_r_i;
            lo_q <= bus.div_q_i;
        end else if (cap_dz) begin
            hi_q <= bus.rs_i;
            lo_q <= 32'hFFFF_FFFF;
        end
    end

    assign bus.mul_ce_o       = (state_q == S_MUL);
    assign bus.mul_sign_o     = launch ? ~bus.op_i[0] : sign_q;
    assign bus.mul_sclr_o     = rst_ni && bus.flush_i;
    assign bus.div_start_o    = launch && is_div && !rt_zero;
    assign bus.div_signed_o   = launch ? ~bus.op_i[0] : sign_q;
    assign bus.div_cancel_o   = bus.flush_i && (state_q == S_DIV_WAIT);
    assign bus.stall_o        = (launch || state_q == S_MUL || state_q == S_MUL_CAP ||
                                 state_q == S_DIV_WAIT) && !bus.except_i && !bus.flush_i;
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.result_valid_o = (state_q == S_DONE);
    assign bus.hi_o           = hi_q;
    assign bus.lo_o           = lo_q;
endmodule
